// File: rtl/ALUOpcode.sv
// ALUOpcode: opcode enumeration shared by the ALU and everything that issues
// work to it. Codes 10..15 are unassigned; the ALU returns y=0 for them.
package ALUOpcode;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        OR  = 4'd3,
        XOR = 4'd4,
        SLL = 4'd5,
        SRL = 4'd6,
        SRA = 4'd7,
        SLT = 4'd8,
        MUL = 4'd9
    } t_e;

endpackage

// File: rtl/ArbState.sv
// ArbState: control states of the ALU arbiter.
//   IDLE - choose a requester and accept its operation
//   EXEC - drive the shared ALU until the latency counter expires
//   RESP - present the result to the owning requester
package ArbState;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } t_e;

endpackage

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: constants and helpers for the ALU arbiter.
//   ARB_CNT_W  - width of the execute-cycle counter (latencies up to 15)
//   exec_load  - counter preload for an opcode (latency - 1)
package alu_arbiter_pkg;

    localparam int ARB_CNT_W = 4;

    // The counter counts down to zero, so an op of latency L is loaded with L-1.
    function automatic logic [ARB_CNT_W-1:0] exec_load(
        input ALUOpcode::t_e op,
        input int unsigned   mul_lat,
        input int unsigned   other_lat
    );
        int unsigned lat;
        lat = (op == ALUOpcode::MUL) ? mul_lat : other_lat;
        return ARB_CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: purely combinational 32-bit ALU with wrap-around arithmetic.
// Ports:
//   a, b   in  32  operands (signed where the op needs it)
//   op     in  ALUOpcode::t_e
//   y      out 32  result; 0 for unassigned opcodes
//   zero   out 1   y == 0
module alu_arbiter_alu (
    input  logic [31:0]   a,
    input  logic [31:0]   b,
    input  ALUOpcode::t_e op,
    output logic [31:0]   y,
    output logic          zero
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        y = '0;
        case (op)
            ALUOpcode::ADD: y = a + b;
            ALUOpcode::SUB: y = a - b;
            ALUOpcode::AND: y = a & b;
            ALUOpcode::OR:  y = a | b;
            ALUOpcode::XOR: y = a ^ b;
            ALUOpcode::SLL: y = a << b[4:0];
            ALUOpcode::SRL: y = a >> b[4:0];
            ALUOpcode::SRA: y = $signed(a) >>> b[4:0];
            ALUOpcode::SLT: y = {31'b0, $signed(a) < $signed(b)};
            ALUOpcode::MUL: y = a * b;   // low 32 bits of the product
            default:        y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters with
// valid/ready handshakes on both request and response. Round-robin grant,
// one transaction in flight; MUL is held for MUL_LATENCY execute cycles,
// everything else for OTHER_LATENCY.
//
// Optional build macro: ALU_ARB_STATS_EN adds saturating per-requester grant
// counters on grant_cnt0 / grant_cnt1.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   2-bit request handshake, bit i = requester i
//   req_a0/req_b0/req_op0 requester 0 operation
//   req_a1/req_b1/req_op1 requester 1 operation
//   rsp_valid/rsp_ready   2-bit response handshake, bit i = requester i
//   rsp_y, rsp_zero       shared result bus and its zero flag
//   busy                  controller is not IDLE
//   grant_cnt0/1          (ALU_ARB_STATS_EN only) acceptances per requester
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned MUL_LATENCY   = 3,
    parameter int unsigned OTHER_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [31:0]   req_a0,
    input  logic [31:0]   req_b0,
    input  ALUOpcode::t_e req_op0,
    input  logic [31:0]   req_a1,
    input  logic [31:0]   req_b1,
    input  ALUOpcode::t_e req_op1,
    output logic [1:0]    rsp_valid,
    input  logic [1:0]    rsp_ready,
    output logic [31:0]   rsp_y,
    output logic          rsp_zero,
    output logic          busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [31:0]   grant_cnt0,
    output logic [31:0]   grant_cnt1
`endif
);

    ArbState::t_e         state, state_nxt;
    logic                 last_grant;
    logic                 owner;
    logic                 grant;
    logic                 accept;
    logic [31:0]          a_q, b_q;
    ALUOpcode::t_e        op_q;
    logic [ARB_CNT_W-1:0] cnt;
    logic [31:0]          sel_a, sel_b;
    ALUOpcode::t_e        sel_op;
    logic [31:0]          alu_y;
    logic                 alu_zero;

    alu_arbiter_alu u_alu (
        .a    (a_q),
        .b    (b_q),
        .op   (op_q),
        .y    (alu_y),
        .zero (alu_zero)
    );

    // Round-robin: a lone requester wins; on contention the one that did
    // not win last time goes next.
    always_comb begin
        grant = 1'b0;
        case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

    assign sel_a  = grant ? req_a1  : req_a0;
    assign sel_b  = grant ? req_b1  : req_b0;
    assign sel_op = grant ? req_op1 : req_op0;

    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        accept    = 1'b0;
        rsp_valid = 2'b00;
        case (state)
            ArbState::IDLE: begin
                // Ready is withheld under reset so nothing is acknowledged
                // that the reset edge would then discard.
                if (!rst && req_valid != 2'b00) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    state_nxt        = ArbState::EXEC;
                end
            end
            ArbState::EXEC: begin
                if (cnt == '0) state_nxt = ArbState::RESP;
            end
            ArbState::RESP: begin
                rsp_valid[owner] = 1'b1;
                if (rsp_ready[owner]) state_nxt = ArbState::IDLE;
            end
            default: state_nxt = ArbState::IDLE;
        endcase
    end

    assign busy = (state != ArbState::IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ArbState::IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            // NOTE: the operand/result registers are reset too; there are
            // only a handful of them and rsp_y has a defined reset value.
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= ALUOpcode::ADD;
            cnt        <= '0;
            rsp_y      <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q        <= sel_a;
                b_q        <= sel_b;
                op_q       <= sel_op;
                owner      <= grant;
                last_grant <= grant;
                cnt        <= exec_load(sel_op, MUL_LATENCY, OTHER_LATENCY);
            end
            if (state == ArbState::EXEC) begin
                if (cnt == '0) begin
                    rsp_y    <= alu_y;
                    rsp_zero <= alu_zero;
                end else begin
                    cnt <= cnt - ARB_CNT_W'(1);
                end
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Per-requester acceptance counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (accept) begin
            if (!grant && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 32'd1;
            if (grant  && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with default
// latencies (MUL 3, others 1). Inputs change on the falling edge; outputs are
// sampled 1 ns after the falling edge.
module tb_alu_arbiter;

    logic          clk;
    logic          rst;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [31:0]   req_a0, req_b0, req_a1, req_b1;
    ALUOpcode::t_e req_op0, req_op1;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready;
    logic [31:0]   rsp_y;
    logic          rsp_zero;
    logic          busy;
`ifdef ALU_ARB_STATS_EN
    logic [31:0]   grant_cnt0, grant_cnt1;
`endif

    int checks   = 0;
    int failures = 0;

    alu_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_op0   (req_op0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_op1   (req_op1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issues one operation from requester idx with rsp_ready held high and
    // reports how long acceptance took, the cycles from acceptance to
    // rsp_valid (1 + L), and the observed response.
    task automatic run_txn(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input ALUOpcode::t_e op, output int acc_wait, output int lat,
                           output logic [1:0] rv, output logic [31:0] y, output logic z);
        @(negedge clk);
        if (idx == 0) begin
            req_a0 = a; req_b0 = b; req_op0 = op;
        end else begin
            req_a1 = a; req_b1 = b; req_op1 = op;
        end
        req_valid[idx] = 1'b1;
        rsp_ready      = 2'b11;
        acc_wait       = 0;
        #1;
        while (req_ready[idx] !== 1'b1 && acc_wait < 20) begin
            @(negedge clk); #1;
            acc_wait++;
        end
        @(negedge clk);
        req_valid[idx] = 1'b0;
        lat = 1;
        #1;
        while (rsp_valid === 2'b00 && lat < 40) begin
            @(negedge clk); #1;
            lat++;
        end
        rv = rsp_valid;
        y  = rsp_y;
        z  = rsp_zero;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
        checks++; if (rsp_y !== 32'd0) begin failures++; $display("FAIL reset_rsp_y: got %h expected 0", rsp_y); end
        checks++; if (rsp_zero !== 1'b0) begin failures++; $display("FAIL reset_rsp_zero: got %b expected 0", rsp_zero); end
    endtask

    task automatic test_add();
        int acc, lat; logic [1:0] rv; logic [31:0] y; logic z;
        run_txn(0, 32'd5, 32'd7, ALUOpcode::ADD, acc, lat, rv, y, z);
        checks++; if (acc !== 0) begin failures++; $display("FAIL add_accept_wait: got %0d expected 0", acc); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL add_latency: got %0d expected 2", lat); end
        checks++; if (rv !== 2'b01) begin failures++; $display("FAIL add_rsp_valid: got %b expected 01", rv); end
        checks++; if (y !== 32'd12) begin failures++; $display("FAIL add_y: got %h expected c", y); end
        checks++; if (z !== 1'b0) begin failures++; $display("FAIL add_zero: got %b expected 0", z); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL add_release: rsp_valid=%b busy=%b expected 00/0", rsp_valid, busy); end
    endtask

    task automatic test_mul();
        int acc, lat; logic [1:0] rv; logic [31:0] y; logic z;
        run_txn(1, -32'sd3, 32'd4, ALUOpcode::MUL, acc, lat, rv, y, z);
        checks++; if (lat !== 4) begin failures++; $display("FAIL mul_latency: got %0d expected 4", lat); end
        checks++; if (rv !== 2'b10) begin failures++; $display("FAIL mul_rsp_valid: got %b expected 10", rv); end
        checks++; if (y !== 32'hFFFF_FFF4) begin failures++; $display("FAIL mul_y: got %h expected fffffff4", y); end
        checks++; if (z !== 1'b0) begin failures++; $display("FAIL mul_zero: got %b expected 0", z); end
        run_txn(1, 32'h0001_0000, 32'h0001_0000, ALUOpcode::MUL, acc, lat, rv, y, z);
        checks++; if (lat !== 4) begin failures++; $display("FAIL mulwrap_latency: got %0d expected 4", lat); end
        checks++; if (y !== 32'd0 || z !== 1'b1) begin failures++; $display("FAIL mulwrap_result: got y=%h zero=%b expected 0/1", y, z); end
        run_txn(1, 32'd5, 32'd7, ALUOpcode::SUB, acc, lat, rv, y, z);
        checks++; if (y !== 32'hFFFF_FFFE || lat !== 2) begin failures++; $display("FAIL sub_neg: got y=%h lat=%0d expected fffffffe/2", y, lat); end
    endtask

    task automatic test_unknown_op();
        int acc, lat; logic [1:0] rv; logic [31:0] y; logic z;
        run_txn(0, 32'd123, 32'd456, ALUOpcode::t_e'(4'hF), acc, lat, rv, y, z);
        checks++; if (lat !== 2) begin failures++; $display("FAIL unknown_latency: got %0d expected 2", lat); end
        checks++; if (y !== 32'd0 || z !== 1'b1) begin failures++; $display("FAIL unknown_result: got y=%h zero=%b expected 0/1", y, z); end
    endtask

    task automatic test_round_robin();
        int         gcyc[$];
        logic [1:0] gbits[$];
        logic [1:0] exp_bits [5];
        int         nrsp;
        exp_bits = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        nrsp = 0;
        do_reset();
        @(negedge clk);
        req_a0 = 32'd1;  req_b0 = 32'd2;  req_op0 = ALUOpcode::ADD;
        req_a1 = 32'd10; req_b1 = 32'd20; req_op1 = ALUOpcode::ADD;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int c = 0; c < 13; c++) begin
            #1;
            if (req_ready !== 2'b00) begin
                gcyc.push_back(c);
                gbits.push_back(req_ready);
            end
            if (rsp_valid !== 2'b00) begin
                nrsp++;
                checks++;
                if (!((rsp_valid === 2'b01 && rsp_y === 32'd3) || (rsp_valid === 2'b10 && rsp_y === 32'd30))) begin
                    failures++;
                    $display("FAIL rr_route: cycle %0d rsp_valid=%b y=%0d expected 01/3 or 10/30", c, rsp_valid, rsp_y);
                end
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        checks++; if (gcyc.size() !== 5) begin failures++; $display("FAIL rr_grant_count: got %0d expected 5", gcyc.size()); end
        checks++; if (nrsp !== 4) begin failures++; $display("FAIL rr_rsp_count: got %0d expected 4", nrsp); end
        for (int i = 0; i < 5 && i < gcyc.size(); i++) begin
            checks++;
            if (gbits[i] !== exp_bits[i] || gcyc[i] !== 3 * i) begin
                failures++;
                $display("FAIL rr_grant_%0d: got ready=%b at cycle %0d expected %b at cycle %0d", i, gbits[i], gcyc[i], exp_bits[i], 3 * i);
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        req_a0 = 32'd9; req_b0 = 32'd9; req_op0 = ALUOpcode::SUB;
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        n = 0;
        #1;
        while (req_ready[0] !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
        checks++; if (n >= 20) begin failures++; $display("FAIL bp_accept: timeout got %b expected 01", req_ready); end
        @(negedge clk);
        req_a1 = 32'd4; req_b1 = 32'd6; req_op1 = ALUOpcode::ADD;
        req_valid = 2'b10;
        rsp_ready = 2'b10;          // non-owner ready must be ignored
        n = 0;
        #1;
        while (rsp_valid === 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rsp_valid !== 2'b01 || rsp_y !== 32'd0 || rsp_zero !== 1'b1 || req_ready !== 2'b00) begin
                failures++;
                $display("FAIL bp_hold_%0d: got valid=%b y=%h zero=%b ready=%b expected 01/0/1/00", c, rsp_valid, rsp_y, rsp_zero, req_ready);
            end
            @(negedge clk); #1;
        end
        rsp_ready = 2'b01;
        @(negedge clk); #1;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_next_grant: got %b expected 10", req_ready); end
        rsp_ready = 2'b11;
        @(negedge clk);
        req_valid = 2'b00;
        n = 0;
        #1;
        while (rsp_valid === 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
        checks++; if (rsp_valid !== 2'b10 || rsp_y !== 32'd10) begin failures++; $display("FAIL bp_req1_rsp: got valid=%b y=%0d expected 10/10", rsp_valid, rsp_y); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        @(negedge clk);
        req_a1 = -32'sd3; req_b1 = 32'd4; req_op1 = ALUOpcode::MUL;
        req_valid = 2'b10;
        rsp_ready = 2'b11;
        n = 0;
        #1;
        while (req_ready[1] !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_exec: busy got %b expected 1", busy); end
        rst = 1'b1;
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || rsp_y !== 32'd0) begin failures++; $display("FAIL midrst_state: busy=%b rsp_valid=%b y=%h expected 0/00/0", busy, rsp_valid, rsp_y); end
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (rsp_valid !== 2'b00) n++;
        end
        checks++; if (n !== 0) begin failures++; $display("FAIL midrst_no_rsp: got %0d response cycles expected 0", n); end
        req_a0 = 32'd1; req_b0 = 32'd1; req_op0 = ALUOpcode::ADD;
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL midrst_first_grant: got %b expected 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        repeat (4) @(negedge clk);
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic test_stats();
        int acc, lat; logic [1:0] rv; logic [31:0] y; logic z;
        do_reset();
        #1;
        checks++; if (grant_cnt0 !== 32'd0 || grant_cnt1 !== 32'd0) begin failures++; $display("FAIL stats_reset: got %0d/%0d expected 0/0", grant_cnt0, grant_cnt1); end
        for (int i = 0; i < 3; i++) run_txn(0, 32'd1, 32'd2, ALUOpcode::ADD, acc, lat, rv, y, z);
        for (int i = 0; i < 2; i++) run_txn(1, 32'd1, 32'd2, ALUOpcode::ADD, acc, lat, rv, y, z);
        @(negedge clk); #1;
        checks++; if (grant_cnt0 !== 32'd3) begin failures++; $display("FAIL stats_cnt0: got %0d expected 3", grant_cnt0); end
        checks++; if (grant_cnt1 !== 32'd2) begin failures++; $display("FAIL stats_cnt1: got %0d expected 2", grant_cnt1); end
        do_reset();
        #1;
        checks++; if (grant_cnt0 !== 32'd0 || grant_cnt1 !== 32'd0) begin failures++; $display("FAIL stats_rereset: got %0d/%0d expected 0/0", grant_cnt0, grant_cnt1); end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_a0 = '0; req_b0 = '0; req_op0 = ALUOpcode::ADD;
        req_a1 = '0; req_b1 = '0; req_op1 = ALUOpcode::ADD;
        repeat (2) @(posedge clk);
        test_reset();
        test_add();
        test_mul();
        test_unknown_op();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one instance of the combinational 32-bit ALU between two requesters (e.g. main pipeline and an address/loop unit) using valid/ready handshakes on request and response.
- Round-robin arbitration, one transaction in flight at a time.
- Operands and opcode are registered before use.
- MUL is held for a configurable number of cycles to model a multi-cycle multiplier; all other ops take one execute cycle.

Parameters:
MUL_LATENCY, 3, execute cycles for ALUOpcode::MUL (legal range 1..15)
OTHER_LATENCY, 1, execute cycles for every other opcode (legal range 1..15)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  2  bit i: requester i presents an operation
req_ready  out  2  bit i: requester i's operation accepted this cycle
req_a0, req_b0  in  32 each  requester 0 operands, signed
req_op0  in  ALUOpcode::t_e  requester 0 opcode
req_a1, req_b1  in  32 each  requester 1 operands, signed
req_op1  in  ALUOpcode::t_e  requester 1 opcode
rsp_valid  out  2  bit i: result for requester i is valid
rsp_ready  in  2  bit i: requester i takes the result
rsp_y  out  32  result, shared bus, meaningful only while rsp_valid is non-zero
rsp_zero  out  1  zero flag for rsp_y
busy  out  1  state is not IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values: state=IDLE, last_grant=1 (requester 0 wins first), req_ready=0, rsp_valid=0, rsp_y=0, rsp_zero=0, busy=0, counter=0.
- FSM states, held in ArbState::t_e:
  - IDLE: grant = the single valid requester; if both are valid, the one not equal to last_grant.
    - req_ready[grant] is asserted combinationally in IDLE only. At most one ready bit is high; a ready bit is never high without its valid bit.
    - On acceptance (valid&ready): latch a, b, op and owner; load counter = MUL_LATENCY-1 if op==MUL, else OTHER_LATENCY-1; last_grant=owner; go to EXEC.
    - With no valid request, stay in IDLE.
  - EXEC: the shared ALU is driven from the registered operands every cycle.
    - If counter==0: latch ALU y/zero into the result registers and go to RESP.
    - Otherwise decrement the counter.
  - RESP: rsp_valid[owner]=1; rsp_y and rsp_zero are held stable.
    - When rsp_ready[owner]=1: clear rsp_valid and go to IDLE.
    - The next grant is not evaluated in the same cycle; the earliest next acceptance is the following cycle.
    - rsp_ready of the non-owner is ignored.
- Latency: acceptance at cycle T gives rsp_valid at T+1+L, where L = MUL_LATENCY or OTHER_LATENCY. Back-to-back throughput is one transaction per L+2 cycles when rsp_ready is held high.
- Requests held during EXEC/RESP are not acknowledged. A requester must keep req_valid and its operands stable until ready.
- Unknown opcode: executes with OTHER_LATENCY; result is the ALU default (y=0, zero=1).
- Arithmetic: purely the ALU's 32-bit wrap semantics (MUL keeps the low 32 bits; SLL uses b as shift amount); no widening.
- Reset mid-transaction (any state): the transaction is discarded, no response is issued, and all reset values are restored on the next edge.

Optional Feature:
Macro ALU_ARB_STATS_EN.
- Defined: adds outputs grant_cnt0 and grant_cnt1 (32 bits each).
  - Each increments on an acceptance for that requester and saturates at 0xFFFFFFFF.
  - Both reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package:
  - ArbState::t_e {IDLE, EXEC, RESP}, wrapped in a package-scoped class/namespace like ALUOpcode.
  - Constant ARB_CNT_W=4 (counter width).
  - Existing ALUOpcode::t_e is reused.
- Sub-module: one instance of ALU (a, b, opcode from the registered operands).
- Arbitration is small enough to stay inline.

Test Plan:
- Single ADD from req 0: a=5, b=7, rsp_ready=1. Expect accept at T, rsp_valid=2'b01 at T+2, y=12, zero=0.
- MUL from req 1, defaults: a=-3, b=4. Expect rsp_valid=2'b10 at T+4, y=-12. Same test with a=0x10000, b=0x10000: y=0, zero=1.
- Both valid every cycle, ADD ops. Grants alternate 0,1,0,1 starting with 0. Each response is routed to the correct bit. Throughput is one per 3 cycles.
- Backpressure: rsp_ready low for 5 cycles during a SUB 9-9. rsp_valid, y=0 and zero=1 stay stable. req_ready stays 0 for the other requester throughout.
- Reset asserted during EXEC of a MUL. Next cycle: state=IDLE, busy=0, rsp_valid=0. The subsequent first grant goes to requester 0.
- With ALU_ARB_STATS_EN, 3 req0 and 2 req1 transactions: grant_cnt0=3, grant_cnt1=2. Both read 0 after reset.
